// File: rtl/fetch_decode_reg_pkg.sv
// Shared fetch/decode pipeline constants, widths and boundary-register state encoding.
package fetch_decode_reg_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 16;

    localparam logic [3:0]         ITYPE_OPCODE_DEF = 4'd8;
    localparam logic [INSTR_W-1:0] NOP_WORD_DEF     = 16'd0;

    typedef enum logic {
        NORMAL   = 1'b0,
        WAIT_IMM = 1'b1
    } fd_state_e;

endpackage

// File: rtl/fetch_decode_reg_pipe_reg.sv
// Width-parameterised pipeline register: async active-low reset, sync clear, enable.
module pipe_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear outranks enable so a flush lands even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (i_clr) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_decode_reg.sv
// Fetch/decode boundary register: merges two-word I-type instructions, applies stall/flush/bubbles.
module fetch_decode_reg
    import fetch_decode_reg_pkg::*;
#(
    parameter logic [3:0]         ITYPE_OPCODE = ITYPE_OPCODE_DEF,
    parameter logic [INSTR_W-1:0] NOP_WORD     = NOP_WORD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_if,
    input  logic [INSTR_W-1:0] instr_if,
    input  logic [INSTR_W-1:0] data_if,
    input  logic               int_if,
    input  logic               stall,
    input  logic               flush,
    output logic [PC_W-1:0]    pc_id,
    output logic [INSTR_W-1:0] instr_id,
    output logic [INSTR_W-1:0] imm_id,
    output logic               valid_id,
    output logic               itype_id,
    output logic               int_id,
    output logic               busy
);

    fd_state_e          r_state;
    fd_state_e          w_state_nxt;
    logic               r_int_pending;
    logic               w_emit;
    logic               w_capture;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [INSTR_W-1:0] w_imm_nxt;
    logic               w_itype_nxt;
    logic               w_int_nxt;
    logic [PC_W-1:0]    w_hold_pc;
    logic [INSTR_W-1:0] w_hold_instr;
    logic [2:0]         w_flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_capture   = 1'b0;
        w_pc_nxt    = pc_if;
        w_instr_nxt = NOP_WORD;
        w_imm_nxt   = '0;
        w_itype_nxt = 1'b0;
        if (flush) begin
            w_state_nxt = NORMAL;
        end else if (!stall) begin
            unique case (r_state)
                NORMAL: begin
                    if (instr_if[15:12] == ITYPE_OPCODE) begin
                        w_capture   = 1'b1;
                        w_state_nxt = WAIT_IMM;
                    end else begin
                        w_emit      = 1'b1;
                        w_instr_nxt = instr_if;
                    end
                end
                WAIT_IMM: begin
                    // The immediate word is consumed raw; its opcode bits are ignored.
                    w_emit      = 1'b1;
                    w_pc_nxt    = w_hold_pc;
                    w_instr_nxt = w_hold_instr;
                    w_imm_nxt   = data_if;
                    w_itype_nxt = 1'b1;
                    w_state_nxt = NORMAL;
                end
                default: w_state_nxt = NORMAL;
            endcase
        end
    end

    assign w_int_nxt = w_emit & (r_int_pending | int_if);

    // Pending interrupt waits for the next emitted instruction; bubbles and flushes keep it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_int_pending <= 1'b0;
        end else if (w_emit) begin
            r_int_pending <= 1'b0;
        end else if (int_if) begin
            r_int_pending <= 1'b1;
        end
    end

    pipe_reg #(.W(PC_W)) u_hold_pc (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (flush),
        .i_en  (w_capture),
        .i_d   (pc_if),
        .o_q   (w_hold_pc)
    );

    pipe_reg #(.W(INSTR_W)) u_hold_instr (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (flush),
        .i_en  (w_capture),
        .i_d   (instr_if),
        .o_q   (w_hold_instr)
    );

    // A bubble leaves pc_id untouched, so the PC only loads on emission.
    pipe_reg #(.W(PC_W)) u_pc_id (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (1'b0),
        .i_en  (w_emit),
        .i_d   (w_pc_nxt),
        .o_q   (pc_id)
    );

    pipe_reg #(.W(INSTR_W), .RST_VAL(NOP_WORD)) u_instr_id (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (flush),
        .i_en  (!stall),
        .i_d   (w_instr_nxt),
        .o_q   (instr_id)
    );

    pipe_reg #(.W(INSTR_W)) u_imm_id (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (flush),
        .i_en  (!stall),
        .i_d   (w_imm_nxt),
        .o_q   (imm_id)
    );

    pipe_reg #(.W(3)) u_flags (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (flush),
        .i_en  (!stall),
        .i_d   ({w_emit, w_itype_nxt, w_int_nxt}),
        .o_q   (w_flags)
    );

    assign valid_id = w_flags[2];
    assign itype_id = w_flags[1];
    assign int_id   = w_flags[0];
    assign busy     = (r_state == WAIT_IMM);

endmodule
